seg_add_pipe: RTL

SEG_ADD_PIPE -- requirements
Module: seg_add_pipe

---
 rtl/seg_add_if.sv | 27 ++
 rtl/seg_add_pipe.sv | 92 +++++++++
 2 files changed

// File: rtl/seg_add_if.sv
// Operand/result handshake bundle for seg_add_pipe.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface seg_add_if #(
   parameter int unsigned W = 16
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/seg_add_pipe.sv
// Segmented pipelined adder/subtractor: stage k adds N-bit segment k, carries ripple
// through registers, and skew registers keep every segment of a beat aligned.
module seg_add_pipe #(
   parameter int unsigned W = 16,
   parameter int unsigned N = 4
) (
   input logic      clk,
   input logic      rst,
   seg_add_if.slave bus
);
   localparam int unsigned NS = (N < 1) ? 1 : N;
   localparam int unsigned S  = W / NS;

   if ((N < 1) || ((W % NS) != 0) || (W < NS)) begin : g_bad_param
      $error("seg_add_pipe: W must be a nonzero multiple of N");
   end

   logic en;

   logic         v_q  [S];
   logic         c_q  [S];
   logic [W-1:0] a_q  [S];
   logic [W-1:0] bx_q [S];
   logic [W-1:0] s_q  [S];
   logic         ovf_q;

   logic         v_in  [S];
   logic         c_in  [S];
   logic [W-1:0] a_in  [S];
   logic [W-1:0] bx_in [S];
   logic [W-1:0] s_in  [S];
   logic [N:0]   seg   [S];
   logic         c_d   [S];
   logic [W-1:0] s_d   [S];
   logic         ovf_d;

   // One global enable: the whole pipe freezes while the output beat is held.
   assign en           = !v_q[S-1] || bus.out_ready;
   assign bus.in_ready = en && !rst;

   always_comb begin
      // Stage 0 takes the live operands; sub is folded into b at acceptance.
      v_in[0]  = bus.in_valid && bus.in_ready;
      a_in[0]  = bus.a;
      bx_in[0] = bus.sub ? ~bus.b : bus.b;
      s_in[0]  = '0;
      c_in[0]  = bus.cin;
      for (int k = 1; k < S; k++) begin
         v_in[k]  = v_q[k-1];
         a_in[k]  = a_q[k-1];
         bx_in[k] = bx_q[k-1];
         s_in[k]  = s_q[k-1];
         c_in[k]  = c_q[k-1];
      end
      for (int k = 0; k < S; k++) begin
         seg[k] = {1'b0, a_in[k][k*N +: N]} + {1'b0, bx_in[k][k*N +: N]}
                  + {{N{1'b0}}, c_in[k]};
         s_d[k] = s_in[k];
         s_d[k][k*N +: N] = seg[k][N-1:0];
         c_d[k] = seg[k][N];
      end
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      ovf_d = a_in[S-1][W-1] ^ bx_in[S-1][W-1] ^ s_d[S-1][W-1] ^ c_d[S-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < S; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            a_q[k]  <= '0;
            bx_q[k] <= '0;
            s_q[k]  <= '0;
         end
         ovf_q <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < S; k++) begin
            v_q[k]  <= v_in[k];
            c_q[k]  <= c_d[k];
            a_q[k]  <= a_in[k];
            bx_q[k] <= bx_in[k];
            s_q[k]  <= s_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.out_valid = v_q[S-1];
   assign bus.sum       = s_q[S-1];
   assign bus.cout      = c_q[S-1];
   assign bus.ovf       = ovf_q;
endmodule
